// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state type and constants for the fetch PC redirect unit
package pc_pkg;
  typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_FLUSH} pc_state_t;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/branch_target.sv
// branch_target: control-flow target adder (branch/JAL vs JALR) and misalignment check
module branch_target
  import pc_pkg::*;
(
  input  logic        ex_jalr_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] target_o,
  output logic        misalign_o
);
  logic [31:0] sum;
  // JALR adds to rs1 and drops bit 0; branch/JAL are PC-relative
  always_comb begin
    sum        = (ex_jalr_i ? rs1_data_i : ex_pc_i) + ex_imm_i;
    target_o   = ex_jalr_i ? (sum & ~32'h1) : sum;
    misalign_o = target_o[1:0] != 2'b00;
  end
endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC register, redirect FSM and IF/ID flush; PC_REDIRECT_PERF_EN adds branch counters
module pc_redirect
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic        ex_jal_i,
  input  logic        ex_jalr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o,
`endif
  output logic        misalign_o
);
  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d, target;
  logic [2:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d, flush_q, fv_q, tgt_mis, redirect;

  branch_target u_target (
    .ex_jalr_i  (ex_jalr_i),
    .ex_pc_i    (ex_pc_i),
    .ex_imm_i   (ex_imm_i),
    .rs1_data_i (rs1_data_i),
    .target_o   (target),
    .misalign_o (tgt_mis)
  );

  assign redirect = ex_valid_i && ((ex_branch_i && branch_taken_i) || ex_jal_i || ex_jalr_i);

  // Next-state: redirect beats stall in RUN; FLUSH ignores EX since those slots are wrong-path
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN:
        if (redirect && !tgt_mis) begin
          pc_d    = target;
          cnt_d   = 3'(FLUSH_DEPTH - 1);
          state_d = PC_FLUSH;
        end else begin
          mis_d = redirect;
          pc_d  = stall_i ? pc_q : pc_q + INSTR_BYTES;
        end
      PC_FLUSH:
        if (!stall_i) begin
          pc_d    = pc_q + INSTR_BYTES;
          cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
          state_d = (cnt_q == 3'd0) ? PC_RUN : PC_FLUSH;
        end
      default: state_d = PC_BOOT;
    endcase
  end

  // State, PC and registered outputs; async reset returns to BOOT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
      flush_q <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      flush_q <= state_d == PC_FLUSH;
      fv_q    <= state_d != PC_BOOT;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fv_q;
  assign flush_o       = flush_q;
  assign misalign_o    = mis_q;

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] br_cnt_q, tk_cnt_q;
  logic        count_br;
  assign count_br = state_q == PC_RUN && ex_valid_i && ex_branch_i;
  // Conditional-branch resolved/taken counters, wrapping at 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else if (count_br) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      tk_cnt_q <= tk_cnt_q + {31'd0, branch_taken_i};
    end
  end
  assign branch_cnt_o = br_cnt_q;
  assign taken_cnt_o  = tk_cnt_q;
`endif
endmodule

// File: tb/tb_pc_redirect.sv
// tb_pc_redirect: directed scoreboard bench for pc_redirect (RESET_PC=0x100, FLUSH_DEPTH=2)
module tb_pc_redirect;
  import pc_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        ms;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_branch, ex_jal, ex_jalr, taken;
  logic [31:0] ex_pc, ex_imm, rs1, pc;
  logic        fv, fl, ms;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] br_cnt, tk_cnt;
`endif
  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pc_redirect #(.RESET_PC(32'h100), .FLUSH_DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .ex_valid_i     (ex_valid),
    .ex_branch_i    (ex_branch),
    .ex_jal_i       (ex_jal),
    .ex_jalr_i      (ex_jalr),
    .branch_taken_i (taken),
    .ex_pc_i        (ex_pc),
    .ex_imm_i       (ex_imm),
    .rs1_data_i     (rs1),
    .pc_o           (pc),
    .fetch_valid_o  (fv),
    .flush_o        (fl),
`ifdef PC_REDIRECT_PERF_EN
    .branch_cnt_o   (br_cnt),
    .taken_cnt_o    (tk_cnt),
`endif
    .misalign_o     (ms)
  );

  task automatic push(input string tag, input logic [31:0] p, input logic v, input logic f, input logic m);
    exp_t e;
    e.tag = tag; e.pc = p; e.fv = v; e.fl = f; e.ms = m;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin n_fail++; $error("FAIL scoreboard_empty: got 0 entries, need 1"); end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (pc === e.pc) else begin n_fail++; $error("FAIL %s pc: got %h exp %h", e.tag, pc, e.pc); end
      n_assert++;
      assert (fv === e.fv) else begin n_fail++; $error("FAIL %s fetch_valid: got %b exp %b", e.tag, fv, e.fv); end
      n_assert++;
      assert (fl === e.fl) else begin n_fail++; $error("FAIL %s flush: got %b exp %b", e.tag, fl, e.fl); end
      n_assert++;
      assert (ms === e.ms) else begin n_fail++; $error("FAIL %s misalign: got %b exp %b", e.tag, ms, e.ms); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic drive(input logic v, input logic b, input logic t, input logic j, input logic r,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] s);
    ex_valid = v; ex_branch = b; taken = t; ex_jal = j; ex_jalr = r;
    ex_pc = p; ex_imm = i; rs1 = s;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    push("reset", 32'h100, 0, 0, 0); check();
    rst_n = 1'b1;
    push("boot", 32'h100, 0, 0, 0); check();
    push("run0", 32'h100, 1, 0, 0); tick();
    push("run1", 32'h104, 1, 0, 0); tick();
    push("run2", 32'h108, 1, 0, 0); tick();
    push("run3", 32'h10C, 1, 0, 0); tick();
    // taken BEQ, then a redirect held through FLUSH and its exit must be ignored
    drive(1, 1, 1, 0, 0, 32'h200, 32'h40, 0);
    push("beq", 32'h240, 1, 1, 0); tick();
    drive(1, 0, 0, 1, 0, 32'h300, 32'h40, 0);
    push("flush_ign", 32'h244, 1, 1, 0); tick();
    push("flush_exit", 32'h248, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("after_flush", 32'h24C, 1, 0, 0); tick();
    // not-taken branch and invalid JAL do nothing
    drive(1, 1, 0, 0, 0, 32'h24C, 32'h80, 0);
    push("beq_nt", 32'h250, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 32'h250, 32'h80, 0);
    push("jal_inv", 32'h254, 1, 0, 0); tick();
    // JALR aligned and misaligned
    drive(1, 0, 0, 0, 1, 32'h254, 32'h3, 32'h1001);
    push("jalr", 32'h1004, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("jalr_f", 32'h1008, 1, 1, 0); tick();
    push("jalr_x", 32'h100C, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 32'h100C, 32'h1, 32'h1001);
    push("jalr_mis", 32'h1010, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("mis_drop", 32'h1014, 1, 0, 0); tick();
    // stall in RUN freezes PC; taken branch still redirects; stall extends FLUSH
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin push("stall", 32'h1014, 1, 0, 0); tick(); end
    drive(1, 1, 1, 0, 0, 32'h2000, 32'h10, 0);
    push("stall_br", 32'h2010, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin push("flush_stall", 32'h2010, 1, 1, 0); tick(); end
    stall = 1'b0;
    push("flush_rel", 32'h2014, 1, 1, 0); tick();
    push("flush_end", 32'h2018, 1, 0, 0); tick();
    // wrap-around past 0xFFFF_FFFC
    drive(1, 0, 0, 1, 0, 32'hFFFF_FF00, 32'hFC, 0);
    push("jal_top", 32'hFFFF_FFFC, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("wrap", 32'h0, 1, 1, 0); tick();
    push("wrap_run", 32'h4, 1, 0, 0); tick();
    // JALR wins over JAL and branch
    drive(1, 1, 1, 1, 1, 32'h500, 32'h20, 32'h800);
    push("prio", 32'h820, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // async reset mid-FLUSH
    rst_n = 1'b0;
    #1;
    push("rst_flush", 32'h100, 0, 0, 0); check();
    rst_n = 1'b1;
    push("rst_run", 32'h100, 1, 0, 0); tick();
`ifdef PC_REDIRECT_PERF_EN
    n_assert++;
    assert (br_cnt === 32'd0 && tk_cnt === 32'd0) else begin n_fail++; $error("FAIL perf_reset: got %0d/%0d exp 0/0", br_cnt, tk_cnt); end
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, (k == 1 || k == 3), 0, 0, 32'h400, 32'h20, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) begin @(posedge clk); #1; end
    end
    n_assert++;
    assert (br_cnt === 32'd5) else begin n_fail++; $error("FAIL perf_branch: got %0d exp 5", br_cnt); end
    n_assert++;
    assert (tk_cnt === 32'd2) else begin n_fail++; $error("FAIL perf_taken: got %0d exp 2", tk_cnt); end
`endif
    n_assert++;
    assert (sb.size() == 0) else begin n_fail++; $error("FAIL scoreboard_left: got %0d entries, need 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect.md
# pc_redirect

Fetch-side program-counter register and control-flow redirect unit. It sits directly downstream of the branch comparator: it consumes the comparator's `branch_taken` result together with the EX-stage jump and branch decode. It computes the control-flow target, updates the fetch PC, and squashes wrong-path instructions in IF/ID through a small flush state machine.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: fetch address loaded on reset.
- `FLUSH_DEPTH`, default `2`: number of cycles `flush_o` is held after a redirect (in-flight IF and ID slots). Legal range 1–7.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: hazard-unit stall; holds PC and flush counter.
- `ex_valid_i` in 1: the EX-stage instruction is valid.
- `ex_branch_i` in 1: EX holds a conditional branch.
- `ex_jal_i` in 1: EX holds JAL.
- `ex_jalr_i` in 1: EX holds JALR.
- `branch_taken_i` in 1: taken result from the branch comparator.
- `ex_pc_i` in 32: PC of the EX instruction.
- `ex_imm_i` in 32: sign-extended immediate.
- `rs1_data_i` in 32: forwarded rs1 value, used by JALR.
- `pc_o` out 32: current fetch address.
- `fetch_valid_o` out 1: `pc_o` is a valid fetch request.
- `flush_o` out 1: squash IF/ID contents.
- `misalign_o` out 1: one-cycle pulse when a redirect target is misaligned.
- `branch_cnt_o` out 32: conditional branches resolved. Present only with `PC_REDIRECT_PERF_EN`.
- `taken_cnt_o` out 32: conditional branches taken. Present only with `PC_REDIRECT_PERF_EN`.

## Operation
- Target computation:
  - Branch or JAL: `ex_pc_i + ex_imm_i`.
  - JALR: `(rs1_data_i + ex_imm_i) & ~32'h1`.
  - All additions are 32-bit modulo, with no overflow flag.
- Redirect request: `ex_valid_i && ((ex_branch_i && branch_taken_i) || ex_jal_i || ex_jalr_i)`, evaluated only in RUN. If more than one of branch, JAL and JALR is asserted, JALR wins, then JAL.
- Misaligned target (`target[1:0] != 0`): the redirect is suppressed. `misalign_o` pulses for one cycle and the PC continues sequentially. Trap entry is outside this block.
- FSM states:
  - BOOT: entered on reset. `fetch_valid_o = 0` and the PC is held. Goes unconditionally to RUN after one cycle.
  - RUN: `fetch_valid_o = 1`. With a valid redirect: PC loads the target, `flush_o` is set, the counter loads `FLUSH_DEPTH-1`, and the FSM goes to FLUSH. Otherwise, PC advances by 4 unless `stall_i` is high.
  - FLUSH: `flush_o = 1` and EX redirect inputs are ignored (those instructions are wrong-path). PC advances by 4 unless stalled. The counter decrements when not stalled. The FSM returns to RUN when the counter is 0 and `stall_i` is low.
- Priority: a redirect overrides `stall_i` in RUN, because the resolving instruction has already left ID.
- Wrap-around: `0xFFFF_FFFC + 4` gives `0x0000_0000`, with no error.

## Timing
- Reset values:
  - `pc_o = RESET_PC`
  - `fetch_valid_o = 0`
  - `flush_o = 0`
  - `misalign_o = 0`
  - FSM in BOOT
  - counters 0
- All outputs are registered.
- Redirect latency: with a redirect in EX at cycle N, `pc_o = target` and `flush_o = 1` from cycle N+1. `flush_o` stays high for exactly `FLUSH_DEPTH` unstalled cycles.
- `misalign_o` is high only in cycle N+1.
- Reset asserted mid-FLUSH: return to BOOT immediately (asynchronously) and clear `flush_o`.
- A redirect arriving in the cycle that FLUSH exits to RUN is ignored. It is a wrong-path slot.

## Configuration
- `PC_REDIRECT_PERF_EN` defined:
  - `branch_cnt_o` and `taken_cnt_o` exist.
  - Both increment on a counted conditional branch: `ex_valid_i && ex_branch_i` in RUN. `taken_cnt_o` increments only if `branch_taken_i` is also high.
  - Both counters wrap at 2^32.
- Undefined: the ports and counter registers are absent. All other behaviour is identical.

## Structure
- Shared package `pc_pkg`:
  - `pc_state_t` enum: PC_BOOT, PC_RUN, PC_FLUSH.
  - `INSTR_BYTES = 4`.
  - Default `RESET_PC`.
- One sub-module, `branch_target`: combinational target adder plus the misalignment check. The FSM, PC register and counters live in `pc_redirect`.

## Test plan
- Reset release with `RESET_PC = 0x100` → `fetch_valid_o = 0` for 1 cycle, then `pc_o` = 0x100, 0x104, 0x108.
- BEQ taken, `ex_pc_i = 0x200`, `imm = 0x40` → next cycle `pc_o = 0x240`, `flush_o` high for 2 cycles, a redirect presented during FLUSH is ignored.
- JALR with `rs1 = 0x1001`, `imm = 0x3` → `pc_o = 0x1004`. Same with `imm = 0x1` (target 0x1002) → no redirect, `misalign_o` one-cycle pulse.
- `stall_i` high for 3 cycles in RUN → `pc_o` frozen. Taken branch during stall → redirect still taken. Stall during FLUSH → `flush_o` extended by 3 cycles.
- PC at 0xFFFF_FFFC, no redirect → next `pc_o = 0x0`. `rst_ni` low mid-FLUSH → `flush_o` drops immediately, `pc_o = RESET_PC`.
- With `PC_REDIRECT_PERF_EN`: 5 branches, 2 taken → `branch_cnt_o = 5`, `taken_cnt_o = 2`.
